// File: rtl/weight_bank.sv
`timescale 1ns/1ps
// Symmetric weight store for an N-neuron recurrent layer.
// Only the upper triangle is kept (row-major), so (i,j) and (j,i) share one word.
// After reset, or on request, a fill pass writes DIAG_INIT on the diagonal and
// the current off-diagonal value everywhere else, one entry per cycle.
module weight_bank #(
    parameter int          N         = 4,
    parameter int          IDX_W     = 2,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] DIAG_INIT = 32'h3F800000,
    parameter logic [31:0] OFF_INIT  = 32'hBE4CCCCD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start,
    input  logic             off_load,
    input  logic [31:0]      off_data,
    output logic             init_busy,
    output logic             init_done,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [IDX_W-1:0] wr_col,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_row,
    input  logic [IDX_W-1:0] rd_col,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             err
);
    localparam int DATA_W  = 32;
    localparam int ENTRIES = N * (N + 1) / 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  mem [ENTRIES];
    logic [DATA_W-1:0]  off_val;
    logic [ADDR_W-1:0]  fill_addr;
    logic [IDX_W-1:0]   fill_row, fill_col;
    logic               fill_we, fill_last;

    logic               rd_acc_p0, wr_acc_p0;
    logic [ADDR_W-1:0]  rd_addr_p0, wr_addr_p0;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return int'(idx) < N;
    endfunction

    // Fold (row,col) onto the upper triangle, then row-major offset.
    function automatic logic [ADDR_W-1:0] tri_addr(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        int r, c, a;
        r = (row < col) ? int'(row) : int'(col);
        c = (row < col) ? int'(col) : int'(row);
        a = r * N - (r * (r - 1)) / 2 + (c - r);
        return ADDR_W'(a);
    endfunction

    assign init_busy  = (state == FILL);
    assign rd_acc_p0  = rd_en && (state == IDLE) && idx_ok(rd_row) && idx_ok(rd_col);
    assign wr_acc_p0  = wr_en && (state == IDLE) && idx_ok(wr_row) && idx_ok(wr_col);
    assign rd_addr_p0 = tri_addr(rd_row, rd_col);
    assign wr_addr_p0 = tri_addr(wr_row, wr_col);

    // Next-state logic: a fill runs exactly ENTRIES cycles, restart requests are ignored while busy.
    always_comb begin
        state_n   = state;
        fill_we   = 1'b0;
        fill_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_start) state_n = FILL;
            end
            FILL: begin
                fill_we = 1'b1;
                if (fill_addr == ADDR_W'(ENTRIES - 1)) begin
                    fill_last = 1'b1;
                    state_n   = IDLE;
                end
            end
        endcase
    end

    // State register and fill pointer; pointer is parked at (0,0) so the next fill starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            fill_addr <= '0;
            fill_row  <= '0;
            fill_col  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            init_done <= fill_last;
            if (fill_we) begin
                if (fill_last) begin
                    fill_addr <= '0;
                    fill_row  <= '0;
                    fill_col  <= '0;
                end else begin
                    fill_addr <= fill_addr + ADDR_W'(1);
                    if (fill_col == IDX_W'(N - 1)) begin
                        fill_row <= fill_row + IDX_W'(1);
                        fill_col <= fill_row + IDX_W'(1);
                    end else begin
                        fill_col <= fill_col + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Off-diagonal init value; a reload only affects entries filled afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            off_val <= OFF_INIT;
        end else if (off_load) begin
            off_val <= off_data;
        end
    end

    // Storage: fill writes and user writes never coincide since user writes need IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_we) begin
                mem[fill_addr] <= (fill_row == fill_col) ? DIAG_INIT : off_val;
            end else if (wr_acc_p0) begin
                mem[wr_addr_p0] <= wr_data;
            end
        end
    end

    // p0 -> p1: registered read response (read-first vs. a same-cycle write) and reject flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_acc_p0;
            err      <= (rd_en && !rd_acc_p0) || (wr_en && !wr_acc_p0);
            if (rd_acc_p0) rd_data <= mem[rd_addr_p0];
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
`timescale 1ns/1ps
// Bench for weight_bank: N=4 instance checked through a read scoreboard,
// plus an N=3 instance for out-of-range index handling.
module tb_weight_bank;
    localparam logic [31:0] DIAG = 32'h3F800000;
    localparam logic [31:0] OFF0 = 32'hBE4CCCCD;
    localparam logic [31:0] OFF1 = 32'hBDCCCCCD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_start = 1'b0, off_load = 1'b0;
    logic [31:0] off_data = '0;

    logic        init_busy, init_done, rd_valid, err;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [1:0]  wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
    logic [31:0] wr_data = '0, rd_data;

    logic        init_busy3, init_done3, rd_valid3, err3;
    logic        wr_en3 = 1'b0, rd_en3 = 1'b0;
    logic [1:0]  wr_row3 = '0, wr_col3 = '0, rd_row3 = '0, rd_col3 = '0;
    logic [31:0] wr_data3 = '0, rd_data3;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;
    vec_t tbl [8];

    logic [31:0] model [4][4];

    weight_bank #(.N(4), .IDX_W(2), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .off_load(off_load),
        .off_data(off_data), .init_busy(init_busy), .init_done(init_done),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );

    weight_bank #(.N(3), .IDX_W(2), .ADDR_W(3)) dut3 (
        .clk(clk), .rst(rst), .init_start(init_start), .off_load(off_load),
        .off_data(off_data), .init_busy(init_busy3), .init_done(init_done3),
        .wr_en(wr_en3), .wr_row(wr_row3), .wr_col(wr_col3), .wr_data(wr_data3),
        .rd_en(rd_en3), .rd_row(rd_row3), .rd_col(rd_col3),
        .rd_valid(rd_valid3), .rd_data(rd_data3), .err(err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer for the N=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_latency", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("rd_missing", 32'(rd_valid), 32'd1);
        end
    end

    task automatic model_init(input logic [31:0] off);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                model[i][j] = (i == j) ? DIAG : off;
    endtask

    task automatic model_wr(input int i, input int j, input logic [31:0] d);
        model[i][j] = d;
        model[j][i] = d;
    endtask

    task automatic do_read(input int i, input int j, input logic [31:0] exp);
        exp_t e;
        rd_en  = 1'b1;
        rd_row = 2'(i);
        rd_col = 2'(j);
        e.data = exp;
        e.due  = cyc + 1;
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                do_read(i, j, model[i][j]);
        tick();
    endtask

    task automatic rd3(input int i, input int j, input logic [31:0] exp, input string nm);
        rd_en3  = 1'b1;
        rd_row3 = 2'(i);
        rd_col3 = 2'(j);
        tick();
        rd_en3 = 1'b0;
        check({nm, "_valid"}, 32'(rd_valid3), 32'd1);
        check({nm, "_data"}, rd_data3, exp);
    endtask

    // Watches one fill pass from its first busy cycle; also pokes a rejected
    // read and an ignored init_start while the fill is running.
    task automatic run_fill(input string nm);
        int busy_n = 0;
        int done_at = -1;
        int done_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0; end
            if (k == 2) begin
                check({nm, "_fill_rd_err"}, 32'(err), 32'd1);
                check({nm, "_fill_rd_valid"}, 32'(rd_valid), 32'd0);
                rd_en = 1'b0;
            end
            if (k == 3) init_start = 1'b1;
            if (k == 4) begin
                check({nm, "_fill_start_err"}, 32'(err), 32'd0);
                init_start = 1'b0;
            end
            if (init_busy) busy_n++;
            if (init_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
        check({nm, "_busy_cycles"}, busy_n, 32'd10);
        check({nm, "_done_at"}, done_at, 32'd10);
        check({nm, "_done_count"}, done_n, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'd3, 2'd1, 32'h40000000, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 2'd1, 2'd3, 32'h0,        32'h40000000};
        tbl[2] = '{1'b0, 1'b1, 2'd3, 2'd1, 32'h0,        32'h40000000};
        tbl[3] = '{1'b0, 1'b1, 2'd1, 2'd2, 32'h0,        OFF0};
        tbl[4] = '{1'b1, 1'b1, 2'd0, 2'd2, 32'h3F000000, OFF0};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 2'd2, 32'h0,        32'h3F000000};
        tbl[6] = '{1'b0, 1'b1, 2'd2, 2'd0, 32'h0,        32'h3F000000};
        tbl[7] = '{1'b0, 1'b1, 2'd3, 2'd3, 32'h0,        DIAG};

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        run_fill("boot");
        model_init(OFF0);
        read_all();

        // Table: symmetric write, back-to-back reads, read-first collision
        for (int t = 0; t < 8; t++) begin
            wr_en   = tbl[t].wr;
            rd_en   = tbl[t].rd;
            wr_row  = tbl[t].row;
            wr_col  = tbl[t].col;
            rd_row  = tbl[t].row;
            rd_col  = tbl[t].col;
            wr_data = tbl[t].wdata;
            if (tbl[t].rd) begin
                exp_t e;
                e.data = tbl[t].rexp;
                e.due  = cyc + 1;
                sb.push_back(e);
            end
            if (tbl[t].wr) model_wr(int'(tbl[t].row), int'(tbl[t].col), tbl[t].wdata);
            tick();
            check("tbl_err", 32'(err), 32'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_data", rd_data, DIAG);

        // N=3 instance: out-of-range indices
        rd_en3 = 1'b1; rd_row3 = 2'd3; rd_col3 = 2'd0;
        tick();
        rd_en3 = 1'b0;
        check("n3_rd_oob_err", 32'(err3), 32'd1);
        check("n3_rd_oob_valid", 32'(rd_valid3), 32'd0);
        wr_en3 = 1'b1; wr_row3 = 2'd0; wr_col3 = 2'd3; wr_data3 = 32'hDEADBEEF;
        tick();
        wr_en3 = 1'b0;
        check("n3_wr_oob_err", 32'(err3), 32'd1);
        rd3(1, 1, DIAG, "n3_d11");
        check("n3_err_clear", 32'(err3), 32'd0);
        rd3(0, 2, OFF0, "n3_o02");
        wr_en3 = 1'b1; wr_row3 = 2'd1; wr_col3 = 2'd2; wr_data3 = 32'h12345678;
        tick();
        wr_en3 = 1'b0;
        rd3(2, 1, 32'h12345678, "n3_w21");
        rd3(2, 2, DIAG, "n3_d22");
        rd_en3 = 1'b1; rd_row3 = 2'd0; rd_col3 = 2'd3;
        wr_en3 = 1'b1; wr_row3 = 2'd3; wr_col3 = 2'd0;
        tick();
        rd_en3 = 1'b0;
        wr_en3 = 1'b0;
        check("n3_both_err", 32'(err3), 32'd1);
        check("n3_both_valid", 32'(rd_valid3), 32'd0);
        tick();
        check("n3_both_err_single", 32'(err3), 32'd0);

        // Epsilon reload then re-init
        off_data = OFF1;
        off_load = 1'b1;
        tick();
        off_load   = 1'b0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        run_fill("reload");
        model_init(OFF1);
        read_all();

        // Reset over a pending read, then reset mid-fill
        rd_en = 1'b1; rd_row = 2'd1; rd_col = 2'd1;
        rst = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rdrst_valid", 32'(rd_valid), 32'd0);
        check("rdrst_data", rd_data, 32'd0);
        check("rdrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("mid_busy", 32'(init_busy), 32'd1);
        check("mid_done", 32'(init_done), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_fill("midrst");
        model_init(OFF0);
        read_all();

        check("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
